trng_sampler: RTL and testbench

- Consumer side of the ring-oscillator bank: takes the 4-bit `ro` pair outputs from the bank and returns whitened random words.
- Pipeline: 2-flop synchronizer, divided sample strobe, XOR compression of `ro`, von Neumann debiasing, packing into WIDTH-bit words.
- Delivers words through a single-entry valid/ready output buffer to the TRNG post-processing / AXI wrapper.
- Runs a repetition-count health test on the raw bit stream.

---
 rtl/trng_pkg.sv | 30 +++
 rtl/trng_vn_extractor.sv | 62 ++++++
 rtl/trng_sampler.sv | 134 +++++++++++++
 tb/tb_trng_sampler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: shared types and width helpers for the TRNG sampler.
//   vn_state_t : von Neumann pairing state (first or second bit of a pair)
//   bcnt_w     : width of the packer bit counter (holds 0..WIDTH)
//   div_w      : width of the sample divider counter (holds 0..DIV-1)
//   rcnt_w     : width of the repetition counter (holds 0..RCT_LIMIT)
package trng_pkg;

  typedef enum logic {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_t;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DIV       = 4;
  localparam int DEF_RCT_LIMIT = 32;

  function automatic int bcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // A divide-by-1 counter never leaves 0 but still needs a 1-bit register.
  function automatic int div_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic int rcnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/trng_vn_extractor.sv
// trng_vn_extractor: von Neumann debiaser over the strobed raw bit stream.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : sampling enable; low forces pairing back to the first bit
//   strobe      : a new raw bit is present this cycle
//   raw         : raw bit
//   bit_valid   : an extracted bit is presented this cycle
//   vn_bit      : extracted bit (the first bit of a differing pair)
//
// state     | meaning
// ----------+---------------------------------------------------
// VN_FIRST  | waiting for the first bit of a pair
// VN_SECOND | first bit is in held_q, waiting for the second bit
module trng_vn_extractor
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic strobe,
  input  logic raw,
  output logic bit_valid,
  output logic vn_bit
);

  vn_state_t state_q, state_d;
  logic      held_q, held_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= VN_FIRST;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Pair 01 yields 0 and pair 10 yields 1, i.e. the held first bit.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    bit_valid = 1'b0;
    vn_bit    = held_q;
    if (!en) begin
      state_d = VN_FIRST;
    end else if (strobe) begin
      case (state_q)
        VN_FIRST: begin
          held_d  = raw;
          state_d = VN_SECOND;
        end
        VN_SECOND: begin
          bit_valid = (held_q != raw);
          state_d   = VN_FIRST;
        end
        default: state_d = VN_FIRST;
      endcase
    end
  end

endmodule

// File: rtl/trng_sampler.sv
// trng_sampler: samples the ring-oscillator bank and returns whitened words.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : sampling enable
//   ro[3:0]    : ring-oscillator outputs, asynchronous to clk
//   data_out   : random word, meaningful while valid=1
//   valid      : data_out holds an unconsumed word
//   ready      : consumer takes the word when valid & ready
//   rct_fail   : sticky repetition-count health failure
module trng_sampler
  import trng_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter int RCT_LIMIT = DEF_RCT_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       ro,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             rct_fail
);

  localparam int BW = bcnt_w(WIDTH);
  localparam int DW = div_w(DIV);
  localparam int RW = rcnt_w(RCT_LIMIT);

  localparam logic [BW-1:0] BCNT_FULL = BW'(WIDTH);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [RW-1:0] RCT_MAX   = RW'(RCT_LIMIT);

  logic [3:0]       s1, s2;
  logic [DW-1:0]    div_cnt;
  logic             strobe, raw;
  logic             bit_valid, vn_bit;
  logic [WIDTH-1:0] shreg, shreg_shift;
  logic [BW-1:0]    bcnt;
  logic [RW-1:0]    rcnt, rcnt_nxt;
  logic             last_raw;
  logic             buf_free;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ro;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en)            div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                          div_cnt <= div_cnt + 1'b1;
  end

  assign strobe = en && (div_cnt == DIV_LAST);
  assign raw    = ^s2;

  trng_vn_extractor u_vn (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .strobe    (strobe),
    .raw       (raw),
    .bit_valid (bit_valid),
    .vn_bit    (vn_bit)
  );

  // Run length of the current raw value; rcnt==0 marks "no bit seen since
  // reset/enable". Saturates so a long stuck run cannot wrap back below the limit.
  always_comb begin
    rcnt_nxt = rcnt;
    if (rcnt == '0 || raw != last_raw) rcnt_nxt = RW'(1);
    else if (rcnt != RCT_MAX)          rcnt_nxt = rcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt     <= '0;
      last_raw <= 1'b0;
      rct_fail <= 1'b0;
    end else if (!en) begin
      rcnt <= '0;
    end else if (strobe) begin
      rcnt     <= rcnt_nxt;
      last_raw <= raw;
      if (rcnt_nxt == RCT_MAX) rct_fail <= 1'b1;
    end
  end

  assign buf_free    = !valid || ready;
  assign shreg_shift = {shreg[WIDTH-2:0], vn_bit};

  // bcnt only rests at WIDTH while the output buffer is occupied; a word
  // that completes into a free buffer is loaded straight from the shift path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg    <= '0;
      bcnt     <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      if (valid && ready) valid <= 1'b0;
      if (bcnt == BCNT_FULL) begin
        if (buf_free) begin
          data_out <= shreg;
          valid    <= 1'b1;
          if (bit_valid) begin
            shreg <= shreg_shift;
            bcnt  <= BW'(1);
          end else begin
            bcnt  <= '0;
          end
        end
      end else if (bit_valid) begin
        shreg <= shreg_shift;
        if (bcnt == BCNT_LAST && buf_free) begin
          data_out <= shreg_shift;
          valid    <= 1'b1;
          bcnt     <= '0;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
module tb_trng_sampler;

  localparam int W     = 8;
  localparam int LIMIT = 32;
  localparam int DIVS [2] = '{1, 3};

  logic       clk;
  logic       rst_n, en, ready;
  logic [3:0] ro;
  logic [W-1:0] data1, data3;
  logic       valid1, valid3, fail1, fail3;

  trng_sampler #(.WIDTH(W), .DIV(1), .RCT_LIMIT(LIMIT)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ro(ro),
    .data_out(data1), .valid(valid1), .ready(ready), .rct_fail(fail1)
  );

  trng_sampler #(.WIDTH(W), .DIV(3), .RCT_LIMIT(LIMIT)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .ro(ro),
    .data_out(data3), .valid(valid3), .ready(ready), .rct_fail(fail3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: raw stream seen through a 2-deep delay, strobe every
  // DIV-th enabled cycle, pairs resolved into bits, bits accumulated
  // arithmetically into words, one-word output slot.
  logic [3:0] m_s1, m_s2;
  int         m_n    [2];
  int         m_pend [2];
  int         m_run  [2];
  bit         m_last [2];
  bit         m_fail [2];
  int         m_cnt  [2];
  int         m_acc  [2];
  bit         m_bv   [2];
  logic [7:0] m_bd   [2];

  task automatic model_edge(input bit rst_v, input bit en_v, input bit rdy_v, input logic [3:0] ro_v);
    bit raw;
    raw = ^m_s2;
    for (int i = 0; i < 2; i++) begin
      bit stb, e_ok, e_b, free;
      stb = 0; e_ok = 0; e_b = 0;
      if (!rst_v) begin
        m_n[i] = 0; m_pend[i] = -1; m_run[i] = 0; m_last[i] = 0; m_fail[i] = 0;
        m_cnt[i] = 0; m_acc[i] = 0; m_bv[i] = 0; m_bd[i] = '0;
        continue;
      end
      if (en_v) begin
        m_n[i]++;
        stb = (m_n[i] % DIVS[i]) == 0;
      end else begin
        m_n[i] = 0; m_pend[i] = -1; m_run[i] = 0;
      end
      if (stb) begin
        if (m_run[i] > 0 && raw == m_last[i]) m_run[i]++;
        else m_run[i] = 1;
        m_last[i] = raw;
        if (m_run[i] >= LIMIT) m_fail[i] = 1;
        if (m_pend[i] < 0) m_pend[i] = raw;
        else begin
          if (m_pend[i] != int'(raw)) begin e_ok = 1; e_b = m_pend[i][0]; end
          m_pend[i] = -1;
        end
      end
      free = !m_bv[i] || rdy_v;
      if (m_bv[i] && rdy_v) m_bv[i] = 0;
      if (m_cnt[i] == W) begin
        if (free) begin
          m_bd[i] = 8'(m_acc[i]); m_bv[i] = 1; m_cnt[i] = 0; m_acc[i] = 0;
        end else e_ok = 0;
      end
      if (e_ok) begin
        m_acc[i] = m_acc[i] * 2 + int'(e_b);
        m_cnt[i]++;
        if (m_cnt[i] == W && free) begin
          m_bd[i] = 8'(m_acc[i]); m_bv[i] = 1; m_cnt[i] = 0; m_acc[i] = 0;
        end
      end
    end
    if (!rst_v) begin m_s1 = '0; m_s2 = '0; end
    else begin m_s2 = m_s1; m_s1 = ro_v; end
  endtask

  logic [7:0] cap[$];

  task automatic cyc(input bit rst_v, input bit en_v, input bit rdy_v, input logic [3:0] ro_v);
    rst_n = rst_v; en = en_v; ready = rdy_v; ro = ro_v;
    if (rst_v && valid1 && rdy_v) cap.push_back(data1);
    @(posedge clk);
    model_edge(rst_v, en_v, rdy_v, ro_v);
    #1;
    check_eq("valid_d1", valid1, m_bv[0]);
    check_eq("data_d1",  data1,  m_bd[0]);
    check_eq("fail_d1",  fail1,  m_fail[0]);
    check_eq("valid_d3", valid3, m_bv[1]);
    check_eq("data_d3",  data3,  m_bd[1]);
    check_eq("fail_d3",  fail3,  m_fail[1]);
  endtask

  function automatic logic [3:0] ro_for(input bit b);
    logic [3:0] r;
    r = 4'($urandom_range(0, 15));
    if ((^r) != b) r[0] = ~r[0];
    return r;
  endfunction

  function automatic bit pat(input int mode, input int j);
    logic [15:0] p69;
    p69 = 16'b0110_1001_1001_0110;
    case (mode)
      0:       return bit'(j % 2);
      1:       return bit'(1 - j % 2);
      2:       return p69[15 - (j % 16)];
      3:       return 1'b0;
      default: return bit'($urandom_range(0, 1));
    endcase
  endfunction

  int first_v, first_f;

  // ro is fed two cycles ahead of enable so the first strobe sees pat(mode,0).
  task automatic run_pat(input int mode, input int n, input bit rdy);
    cap.delete();
    first_v = -1; first_f = -1;
    cyc(1, 0, rdy, ro_for(pat(mode, 0)));
    cyc(1, 0, rdy, ro_for(pat(mode, 1)));
    for (int e = 0; e < n; e++) begin
      cyc(1, 1, rdy, ro_for(pat(mode, e + 2)));
      if (first_v < 0 && valid1) first_v = e;
      if (first_f < 0 && fail1)  first_f = e;
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 4'h0);
  endtask

  initial begin
    rst_n = 0; en = 0; ready = 0; ro = '0;
    m_s1 = '0; m_s2 = '0;
    do_reset(3);
    check_eq("rst_valid", valid1, 0);
    check_eq("rst_data",  data1,  0);
    check_eq("rst_fail",  fail1,  0);

    run_pat(0, 40, 1);
    check_eq("p01_words", cap.size() >= 2, 1);
    check_eq("p01_word0", (cap.size() > 0) ? cap[0] : 8'h5a, 8'h00);
    check_eq("p01_lat",   first_v, 15);
    do_reset(2);

    run_pat(1, 40, 1);
    check_eq("p10_word0", (cap.size() > 0) ? cap[0] : 8'h5a, 8'hff);
    do_reset(2);

    run_pat(2, 40, 1);
    check_eq("p69_word0", (cap.size() > 0) ? cap[0] : 8'h5a, 8'h69);
    check_eq("p69_word1", (cap.size() > 1) ? cap[1] : 8'h5a, 8'h69);
    do_reset(2);

    run_pat(3, 40, 1);
    check_eq("zero_words", cap.size(), 0);
    check_eq("rct_lat",    first_f, 31);
    for (int k = 0; k < 4; k++) cyc(1, k[0], 1, 4'h0);
    check_eq("rct_sticky", fail1, 1);
    do_reset(1);
    check_eq("rct_clear",  fail1, 0);

    run_pat(4, 150, 0);
    check_eq("bp_held", valid1, 1);
    cyc(1, 1, 1, ro_for(pat(4, 0)));
    check_eq("bp_nobubble", valid1, 1);
    for (int k = 0; k < 9; k++) cyc(1, 1, 0, ro_for(pat(4, 0)));
    do_reset(1);
    check_eq("midrst_valid", valid1, 0);
    check_eq("midrst_data",  data1,  0);

    for (int k = 0; k < 4000; k++) begin
      bit r;
      r = ($urandom_range(0, 299) != 0);
      cyc(r, $urandom_range(0, 7) != 0, bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
